// File: rtl/if_id_pkg.sv
// Shared opcode/function constants, controller codes and decode helper for the IF/ID hazard stage.
package if_id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [7:0] CTRL_ISSUE  = 8'b0000_0011;
  localparam logic [7:0] CTRL_BUBBLE = 8'b0000_0000;
  localparam logic [4:0] LINK_REG    = 5'd31;

  typedef enum logic [1:0] {
    FMT_R,
    FMT_I,
    FMT_J
  } fmt_e;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  func;
    logic [15:0] immediate;
    logic [25:0] address;
  } fields_t;

  typedef struct packed {
    fields_t    f;
    logic       use_rs;
    logic       use_rt;
    logic [4:0] dest;
  } decode_t;

  function automatic fmt_e instr_fmt(input logic [5:0] op);
    if (op == OP_RTYPE)                return FMT_R;
    else if (op == OP_J || op == OP_JAL) return FMT_J;
    else                                 return FMT_I;
  endfunction

  function automatic decode_t decode(input logic [31:0] w);
    decode_t d;
    d = '0;
    d.f.opcode = w[31:26];
    unique case (instr_fmt(w[31:26]))
      FMT_R: begin
        d.f.rs    = w[25:21];
        d.f.rt    = w[20:16];
        d.f.rd    = w[15:11];
        d.f.shamt = w[10:6];
        d.f.func  = w[5:0];
        if (w[5:0] == FN_JR) begin
          d.use_rs = 1'b1;
        end else if (!w[5]) begin
          d.use_rt = 1'b1;
          d.dest   = w[15:11];
        end else begin
          d.use_rs = 1'b1;
          d.use_rt = 1'b1;
          d.dest   = w[15:11];
        end
      end
      FMT_J: begin
        d.f.address = w[25:0];
        d.dest      = (w[31:26] == OP_JAL) ? LINK_REG : 5'd0;
      end
      default: begin
        d.f.rs        = w[25:21];
        d.f.rt        = w[20:16];
        d.f.rd        = w[20:16];
        d.f.immediate = w[15:0];
        d.use_rs      = 1'b1;
        // sw shares op[3]=1 with the arithmetic group, so it is peeled off first
        if (w[31:26] == OP_SW || w[31:26] == OP_BEQ || w[31:26] == OP_BNE) begin
          d.use_rt = 1'b1;
        end else if (w[31:26] == OP_LW || w[29]) begin
          d.dest = w[20:16];
        end
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/if_id_scoreboard.sv
// In-flight destination shift register with parallel source compare.
module if_id_scoreboard
  import if_id_pkg::*;
#(
  parameter int unsigned HAZ_DEPTH = 3,
  parameter int unsigned REG_AW    = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              shift_i,
  input  logic [REG_AW-1:0] dest_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  output logic              hit_rs_o,
  output logic              hit_rt_o
);

  logic [REG_AW-1:0] slot_q [HAZ_DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < HAZ_DEPTH; i++) slot_q[i] <= '0;
    end else if (shift_i) begin
      slot_q[0] <= dest_i;
      for (int unsigned i = 1; i < HAZ_DEPTH; i++) slot_q[i] <= slot_q[i-1];
    end
  end

  always_comb begin
    hit_rs_o = 1'b0;
    hit_rt_o = 1'b0;
    for (int unsigned i = 0; i < HAZ_DEPTH; i++) begin
      if (slot_q[i] == rs_i) hit_rs_o = 1'b1;
      if (slot_q[i] == rt_i) hit_rt_o = 1'b1;
    end
  end

endmodule

// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with RAW hazard stall, backpressure and flush.
// Define IF_ID_STALL_CNT_EN to add the saturating stall_count_o port.
module if_id_hazard_stage
  import if_id_pkg::*;
#(
  parameter int unsigned HAZ_DEPTH   = 3,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned CTRL_W      = 8,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instr_valid_i,
  input  logic [31:0]       instr_i,
  output logic              instr_ready_o,
  input  logic              flush_i,
  input  logic              id_ready_i,
  output logic              id_valid_o,
  output logic [5:0]        opcode_o,
  output logic [REG_AW-1:0] rs_o,
  output logic [REG_AW-1:0] rt_o,
  output logic [REG_AW-1:0] rd_o,
  output logic [5:0]        func_o,
  output logic [4:0]        shamt_o,
  output logic [15:0]       immediate_o,
  output logic [25:0]       address_o,
  output logic [CTRL_W-1:0] controller_o
`ifdef IF_ID_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_count_o
`endif
);

  decode_t           dec;
  fields_t           out_d, out_q;
  logic              valid_d, valid_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic              advance, hazard, issue, hit_rs, hit_rt;
  logic [REG_AW-1:0] rs_idx, rt_idx, sb_din;

  always_comb begin
    dec     = decode(instr_i);
    rs_idx  = REG_AW'(dec.f.rs);
    rt_idx  = REG_AW'(dec.f.rt);
    advance = id_ready_i | ~valid_q;
    hazard  = instr_valid_i &
              ((dec.use_rs & (rs_idx != '0) & hit_rs) |
               (dec.use_rt & (rt_idx != '0) & hit_rt));
    issue   = advance & ~flush_i & ~hazard & instr_valid_i;
    sb_din  = issue ? REG_AW'(dec.dest) : '0;
    instr_ready_o = ~rst_i & advance & (flush_i | ~hazard);
  end

  if_id_scoreboard #(
    .HAZ_DEPTH (HAZ_DEPTH),
    .REG_AW    (REG_AW)
  ) u_scoreboard (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .shift_i  (advance),
    .dest_i   (sb_din),
    .rs_i     (rs_idx),
    .rt_i     (rt_idx),
    .hit_rs_o (hit_rs),
    .hit_rt_o (hit_rt)
  );

  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    ctrl_d  = ctrl_q;
    if (advance) begin
      valid_d = issue;
      out_d   = issue ? dec.f : '0;
      ctrl_d  = issue ? CTRL_W'(CTRL_ISSUE) : CTRL_W'(CTRL_BUBBLE);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign id_valid_o   = valid_q;
  assign opcode_o     = out_q.opcode;
  assign rs_o         = REG_AW'(out_q.rs);
  assign rt_o         = REG_AW'(out_q.rt);
  assign rd_o         = REG_AW'(out_q.rd);
  assign func_o       = out_q.func;
  assign shamt_o      = out_q.shamt;
  assign immediate_o  = out_q.immediate;
  assign address_o    = out_q.address;
  assign controller_o = ctrl_q;

`ifdef IF_ID_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (advance & hazard & ~flush_i & ~(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Directed bench for if_id_hazard_stage with a per-cycle reference model.
module tb_if_id_hazard_stage;

  localparam int HD = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        flush = 1'b0;
  logic        id_ready = 1'b1;
  logic        instr_ready, id_valid;
  logic [5:0]  opcode, func;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] immediate;
  logic [25:0] address;
  logic [7:0]  controller;
`ifdef IF_ID_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  if_id_hazard_stage #(
    .HAZ_DEPTH   (HD),
    .REG_AW      (5),
    .CTRL_W      (8),
    .STALL_CNT_W (16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .instr_valid_i (instr_valid),
    .instr_i       (instr),
    .instr_ready_o (instr_ready),
    .flush_i       (flush),
    .id_ready_i    (id_ready),
    .id_valid_o    (id_valid),
    .opcode_o      (opcode),
    .rs_o          (rs),
    .rt_o          (rt),
    .rd_o          (rd),
    .func_o        (func),
    .shamt_o       (shamt),
    .immediate_o   (immediate),
    .address_o     (address),
    .controller_o  (controller)
`ifdef IF_ID_STALL_CNT_EN
    ,
    .stall_count_o (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] addr;
  } fl_t;

  fl_t        m_out = '0;
  logic       m_valid = 1'b0;
  logic [7:0] m_ctrl = '0;
  int         m_slot [HD];
  int         m_cnt = 0;

  initial for (int i = 0; i < HD; i++) m_slot[i] = 0;

  // Reference reading of a MIPS word: visible fields, sources read (0 = none), destination written.
  function automatic void classify(input logic [31:0] w, output fl_t f, output int s1,
                                   output int s2, output int dst);
    int op, fr, ft, fd, fn;
    op = int'(w[31:26]); fr = int'(w[25:21]); ft = int'(w[20:16]);
    fd = int'(w[15:11]); fn = int'(w[5:0]);
    f = '0; s1 = 0; s2 = 0; dst = 0;
    f.op = w[31:26];
    if (op == 0) begin
      f.rs = w[25:21]; f.rt = w[20:16]; f.rd = w[15:11]; f.sh = w[10:6]; f.fn = w[5:0];
      if (fn == 8)       s1 = fr;
      else if (fn < 32) begin s2 = ft; dst = fd; end
      else begin s1 = fr; s2 = ft; dst = fd; end
    end else if (op == 2 || op == 3) begin
      f.addr = w[25:0];
      dst = (op == 3) ? 31 : 0;
    end else begin
      f.rs = w[25:21]; f.rt = w[20:16]; f.rd = w[20:16]; f.imm = w[15:0];
      s1 = fr;
      if (op == 4 || op == 5 || op == 43) s2 = ft;
      else if (op == 35 || (op % 16) >= 8) dst = ft;
    end
  endfunction

  function automatic logic in_flight(input int r);
    if (r == 0) return 1'b0;
    for (int i = 0; i < HD; i++) if (m_slot[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_hazard();
    fl_t f; int s1, s2, d;
    classify(instr, f, s1, s2, d);
    return instr_valid && (in_flight(s1) || in_flight(s2));
  endfunction

  function automatic logic m_ready();
    return !rst && (id_ready || !m_valid) && (flush || !m_hazard());
  endfunction

  always @(posedge clk or posedge rst) begin
    fl_t f; int s1, s2, d; logic hz;
    if (rst) begin
      m_valid <= 1'b0; m_out <= '0; m_ctrl <= '0; m_cnt <= 0;
      for (int i = 0; i < HD; i++) m_slot[i] <= 0;
    end else if (id_ready || !m_valid) begin
      classify(instr, f, s1, s2, d);
      hz = m_hazard();
      if (!flush && !hz && instr_valid) begin
        m_valid <= 1'b1; m_out <= f; m_ctrl <= 8'd3; m_slot[0] <= d;
      end else begin
        m_valid <= 1'b0; m_out <= '0; m_ctrl <= 8'd0; m_slot[0] <= 0;
      end
      for (int i = 1; i < HD; i++) m_slot[i] <= m_slot[i-1];
      if (!flush && hz && m_cnt < 65535) m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("id_valid",    id_valid,    m_valid);
      chk("opcode",      opcode,      m_out.op);
      chk("rs",          rs,          m_out.rs);
      chk("rt",          rt,          m_out.rt);
      chk("rd",          rd,          m_out.rd);
      chk("shamt",       shamt,       m_out.sh);
      chk("func",        func,        m_out.fn);
      chk("immediate",   immediate,   m_out.imm);
      chk("address",     address,     m_out.addr);
      chk("controller",  controller,  m_ctrl);
      chk("instr_ready", instr_ready, m_ready());
`ifdef IF_ID_STALL_CNT_EN
      chk("stall_count", stall_count, m_cnt);
`endif
    end
  end

  // Presents w until the model says it is consumed; returns cycles spent waiting.
  task automatic send(input logic [31:0] w, output int stalls);
    logic acc;
    acc = 1'b0;
    stalls = 0;
    instr = w;
    instr_valid = 1'b1;
    for (int n = 0; n < 40 && !acc; n++) begin
      @(negedge clk);
      acc = m_ready();
      @(posedge clk); #1;
      if (!acc) stalls++;
    end
    chk("accept_within_budget", acc, 1);
    instr_valid = 1'b0;
    instr = '0;
  endtask

  function automatic logic [31:0] rtype(input int s, input int t, input int d, input int sh, input int fn);
    return {6'd0, 5'(s), 5'(t), 5'(d), 5'(sh), 6'(fn)};
  endfunction

  int st;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_id_valid",    id_valid,    0);
    chk("reset_controller",  controller,  0);
    chk("reset_rd",          rd,          0);
    chk("reset_instr_ready", instr_ready, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    send(rtype(1, 2, 3, 0, 32), st);
    chk("t1_add3_stalls", st, 0);
    send(rtype(3, 3, 4, 0, 32), st);
    chk("t1_add4_stalls", st, 3);
    chk("t1_rd", rd, 4);
    chk("t1_ctrl", controller, 8'h03);

    send({6'h08, 5'd0, 5'd5, 16'd7}, st);
    chk("t2_addi_imm", immediate, 16'h0007);
    chk("t2_addi_rd", rd, 5);
    send(rtype(0, 0, 6, 2, 0), st);
    chk("t2_sll_stalls", st, 0);
    chk("t2_sll_shamt", shamt, 2);
    send(rtype(6, 0, 7, 1, 0), st);
    chk("t2_sll_rs_ignored", st, 0);

    send(rtype(1, 2, 8, 0, 32), st);
    instr = rtype(8, 0, 9, 0, 32);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    chk("t3_stalled_bubble", id_valid, 0);
    flush = 1'b1;
    @(negedge clk);
    chk("t3_flush_ready", instr_ready, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    instr_valid = 1'b0;
    chk("t3_flush_bubble", id_valid, 0);
    send(rtype(1, 2, 10, 0, 32), st);
    chk("t3_clean_issue", st, 0);

    id_ready = 1'b0;
    instr = {6'h08, 5'd0, 5'd11, 16'd1};
    instr_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t4_hold_rd", rd, 10);
    chk("t4_hold_valid", id_valid, 1);
    id_ready = 1'b1;
    send({6'h08, 5'd0, 5'd11, 16'd1}, st);
    chk("t4_resume_stalls", st, 0);
    chk("t4_resume_rd", rd, 11);

    send({6'h03, 26'h40}, st);
    chk("t5_jal_addr", address, 26'h40);
    chk("t5_jal_rd", rd, 0);
    send(rtype(31, 0, 0, 0, 8), st);
    chk("t5_jr_stalls", st, HD);
    chk("t5_jr_func", func, 6'h08);
`ifdef IF_ID_STALL_CNT_EN
    chk("t5_stall_count_lit", stall_count, 3 + 1 + HD);
`endif

    send(rtype(1, 2, 12, 0, 32), st);
    id_ready = 1'b0;
    instr = rtype(12, 0, 13, 0, 32);
    instr_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_pre_rd", rd, 12);
    chk("t6_pre_ready", instr_ready, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", id_valid, 0);
    chk("t6_rst_rd", rd, 0);
    chk("t6_rst_ctrl", controller, 0);
    chk("t6_rst_ready", instr_ready, 0);
`ifdef IF_ID_STALL_CNT_EN
    chk("t6_rst_count", stall_count, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    id_ready = 1'b1;
    send(rtype(12, 0, 13, 0, 32), st);
    chk("t6_after_reset_stalls", st, 0);
    chk("t6_after_reset_rd", rd, 13);

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
